// File: rtl/ospfb_capture_ctrl.sv
// Capture controller for the OSPFB/FFT output stream.
// Aligns to a frame boundary (tlast), discards SKIP_FRAMES whole frames,
// then writes FRAMES frames into a capture RAM at frame*FFT_LEN + index.
// Any framing error or FFT core event during skip/capture stops the run
// and is latched into err_code.
module ospfb_capture_ctrl #(
   parameter int FFT_LEN     = 2048,
   parameter int WIDTH       = 16,
   parameter int FRAMES      = 20,
   parameter int SKIP_FRAMES = 2,
   localparam int AW         = $clog2(FRAMES*FFT_LEN),
   localparam int FCW        = $clog2(FRAMES+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [2*WIDTH-1:0] s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   input  logic               event_tlast_unexpected,
   input  logic               event_tlast_missing,
   input  logic               event_fft_overflow,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [2*WIDTH-1:0] wr_data,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [2:0]         err_code,
   output logic [FCW-1:0]     frame_count
);

   localparam int IW = $clog2(FFT_LEN);
   // One spare count so the width stays non-zero when SKIP_FRAMES is 0
   localparam int SW = $clog2(SKIP_FRAMES+2);

   localparam logic [IW-1:0]  IDX_LAST  = IW'(FFT_LEN-1);
   localparam logic [SW-1:0]  SKIP_LAST = SW'((SKIP_FRAMES > 0) ? SKIP_FRAMES-1 : 0);
   localparam logic [FCW-1:0] FRM_LAST  = FCW'(FRAMES-1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      SKIP    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4,
      ERROR   = 3'd5
   } state_t;

   state_t         state;
   logic [IW-1:0]  idx;        // sample index within the current frame
   logic [SW-1:0]  skip_cnt;   // frames discarded so far
   logic [AW-1:0]  cap_addr;   // next RAM address; frames are contiguous

   logic beat;
   logic at_last;
   logic tl_bad;
   logic tl_evt;
   logic evt_any;

   // Handshake and framing checks for the beat on the bus this cycle
   assign beat    = s_axis_tvalid & s_axis_tready;
   assign at_last = (idx == IDX_LAST);
   assign tl_bad  = beat & (s_axis_tlast != at_last);
   assign tl_evt  = event_tlast_unexpected | event_tlast_missing;
   assign evt_any = tl_evt | event_fft_overflow;

   // Control FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         s_axis_tready <= 1'b0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= 3'b000;
         frame_count   <= '0;
         idx           <= '0;
         skip_cnt      <= '0;
         cap_addr      <= '0;
      end else begin
         s_axis_tready <= 1'b1;
         wr_en         <= 1'b0;
         if (abort && state != IDLE) begin
            // Abort beats start and events; the beat on the bus is dropped
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE, ERROR: begin
                  if (start && !abort) begin
                     state       <= SYNC;
                     busy        <= 1'b1;
                     done        <= 1'b0;
                     err         <= 1'b0;
                     err_code    <= 3'b000;
                     frame_count <= '0;
                     idx         <= '0;
                     skip_cnt    <= '0;
                     cap_addr    <= '0;
                  end
               end
               SYNC: begin
                  // First tlast marks the end of a partial frame; index 0 follows
                  if (beat && s_axis_tlast) begin
                     idx   <= '0;
                     state <= (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
                  end
               end
               SKIP, CAPTURE: begin
                  if (tl_bad || evt_any) begin
                     // Offending beat is never written; all causes accumulate
                     state    <= ERROR;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     err_code <= err_code | {event_fft_overflow, tl_evt, tl_bad};
                  end else if (beat) begin
                     idx <= idx + IW'(1);
                     if (state == SKIP) begin
                        if (at_last) begin
                           skip_cnt <= skip_cnt + SW'(1);
                           if (skip_cnt == SKIP_LAST) state <= CAPTURE;
                        end
                     end else begin
                        wr_en    <= 1'b1;
                        wr_addr  <= cap_addr;
                        wr_data  <= s_axis_tdata;
                        cap_addr <= cap_addr + AW'(1);
                        if (at_last) begin
                           frame_count <= frame_count + FCW'(1);
                           if (frame_count == FRM_LAST) begin
                              // done rises together with the final write pulse
                              state <= DONE;
                              busy  <= 1'b0;
                              done  <= 1'b1;
                           end
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ospfb_capture_ctrl.sv
// Directed bench for ospfb_capture_ctrl with FFT_LEN=64, FRAMES=4, SKIP_FRAMES=2.
// The stream starts mid-frame at index 10, so 54 beats are discarded, 128
// skipped and capture beat n (addr a) is stream beat 182+a.
module tb_ospfb_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [31:0] tdata;
   logic        tvalid, tready, tlast;
   logic        ev_u, ev_m, ev_o;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy, done, err;
   logic [2:0]  err_code;
   logic [2:0]  frame_count;

   int checks = 0;
   int failures = 0;
   int seq, src_idx;
   int bad_seq = -1;
   int nwr = 0;
   logic [7:0]  log_addr [1024];
   logic [31:0] log_data [1024];
   logic        log_done [1024];

   ospfb_capture_ctrl #(.FFT_LEN(64), .WIDTH(16), .FRAMES(4), .SKIP_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
      .s_axis_tlast(tlast),
      .event_tlast_unexpected(ev_u), .event_tlast_missing(ev_m),
      .event_fft_overflow(ev_o),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Write-port log, sampled away from the rising edge
   always @(negedge clk) begin
      if (wr_en === 1'b1 && nwr < 1024) begin
         log_addr[nwr] = wr_addr;
         log_data[nwr] = wr_data;
         log_done[nwr] = done;
         nwr++;
      end
   end

   function automatic logic [31:0] mk(input int s);
      return {16'(s*3+1), 16'(s ^ 16'hA5A5)};
   endfunction

   // Send n accepted beats; pct is the tvalid probability per cycle
   task automatic send_beats(input int n, input int pct);
      int   sent = 0;
      int   cyc = 0;
      logic v, rdy;
      while (sent < n && cyc < n*20+100) begin
         v      = ($urandom_range(99) < pct);
         rdy    = tready;
         tvalid = v;
         tdata  = mk(seq);
         tlast  = (src_idx == 63) || (seq == bad_seq);
         @(posedge clk); #1;
         cyc++;
         if (v && rdy) begin
            seq++;
            src_idx = (src_idx + 1) % 64;
            sent++;
         end
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      if (sent < n) begin
         checks++; failures++;
         $display("FAIL send_timeout sent=%0d required=%0d", sent, n);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic full_run(input int pct);
      nwr = 0; seq = 0; src_idx = 10;
      pulse_start();
      send_beats(438, pct);
      wait_cyc(3);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      tvalid = 1'b0; tlast = 1'b0; tdata = '0;
      ev_u = 1'b0; ev_m = 1'b0; ev_o = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({tready, wr_en, busy, done, err} !== 5'b0) begin failures++;
         $display("FAIL rst_flags got=%b want=00000", {tready, wr_en, busy, done, err}); end
      checks++; if (err_code !== 3'b000) begin failures++;
         $display("FAIL rst_err_code got=%b want=000", err_code); end
      checks++; if (wr_addr !== 8'd0) begin failures++;
         $display("FAIL rst_wr_addr got=%0d want=0", wr_addr); end
      checks++; if (frame_count !== 3'd0) begin failures++;
         $display("FAIL rst_frame_count got=%0d want=0", frame_count); end
      checks++; if (wr_data !== 32'd0) begin failures++;
         $display("FAIL rst_wr_data got=%h want=0", wr_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      wait_cyc(1);
      checks++; if (tready !== 1'b1 || busy !== 1'b0) begin failures++;
         $display("FAIL post_rst tready=%b busy=%b want 1 0", tready, busy); end
   endtask

   task automatic test_normal();
      nwr = 0; seq = 0; src_idx = 10;
      pulse_start();
      checks++; if (busy !== 1'b1) begin failures++;
         $display("FAIL norm_busy got=%b want=1", busy); end
      send_beats(54, 100);
      checks++; if (nwr !== 0) begin failures++;
         $display("FAIL norm_sync_writes got=%0d want=0", nwr); end
      pulse_start();  // ignored while busy
      send_beats(128, 100);
      checks++; if (nwr !== 0 || busy !== 1'b1) begin failures++;
         $display("FAIL norm_skip writes=%0d busy=%b want 0 1", nwr, busy); end
      send_beats(256, 100);
      wait_cyc(3);
      checks++; if (nwr !== 256) begin failures++;
         $display("FAIL norm_nwr got=%0d want=256", nwr); end
      for (int i = 0; i < 256; i++) begin
         checks++; if (log_addr[i] !== 8'(i) || log_data[i] !== mk(182+i)) begin failures++;
            $display("FAIL norm_write[%0d] addr=%0d data=%h want %0d %h",
                     i, log_addr[i], log_data[i], i, mk(182+i)); end
      end
      checks++; if (log_done[255] !== 1'b1 || log_done[254] !== 1'b0) begin failures++;
         $display("FAIL norm_done_timing got=%b%b want=01", log_done[254], log_done[255]); end
      checks++; if ({done, busy, err} !== 3'b100 || frame_count !== 3'd4) begin failures++;
         $display("FAIL norm_end done/busy/err=%b fc=%0d want 100 4", {done, busy, err}, frame_count); end
      checks++; if (wr_addr !== 8'd255) begin failures++;
         $display("FAIL norm_last_addr got=%0d want=255", wr_addr); end
      send_beats(20, 100);
      checks++; if (nwr !== 256 || done !== 1'b1) begin failures++;
         $display("FAIL norm_after_done nwr=%0d done=%b want 256 1", nwr, done); end
   endtask

   task automatic test_gaps();
      full_run(50);
      checks++; if (nwr !== 256) begin failures++;
         $display("FAIL gap_nwr got=%0d want=256", nwr); end
      for (int i = 0; i < 256; i++) begin
         checks++; if (log_addr[i] !== 8'(i) || log_data[i] !== mk(182+i)) begin failures++;
            $display("FAIL gap_write[%0d] addr=%0d data=%h want %0d %h",
                     i, log_addr[i], log_data[i], i, mk(182+i)); end
      end
      checks++; if (done !== 1'b1 || frame_count !== 3'd4) begin failures++;
         $display("FAIL gap_end done=%b fc=%0d want 1 4", done, frame_count); end
   endtask

   task automatic test_tlast_err();
      nwr = 0; seq = 0; src_idx = 10;
      bad_seq = 182 + 64 + 30;
      pulse_start();
      send_beats(54 + 128 + 95, 100);
      wait_cyc(2);
      bad_seq = -1;
      checks++; if (err !== 1'b1 || err_code !== 3'b001) begin failures++;
         $display("FAIL tl_err err=%b code=%b want 1 001", err, err_code); end
      checks++; if (frame_count !== 3'd1) begin failures++;
         $display("FAIL tl_fc got=%0d want=1", frame_count); end
      checks++; if (nwr !== 94 || wr_addr !== 8'd93) begin failures++;
         $display("FAIL tl_writes nwr=%0d last=%0d want 94 93", nwr, wr_addr); end
      checks++; if ({busy, done, wr_en} !== 3'b000) begin failures++;
         $display("FAIL tl_flags busy/done/wr_en=%b want 000", {busy, done, wr_en}); end
      send_beats(30, 100);
      checks++; if (nwr !== 94 || err !== 1'b1) begin failures++;
         $display("FAIL tl_held nwr=%0d err=%b want 94 1", nwr, err); end
   endtask

   task automatic test_overflow();
      nwr = 0; seq = 0; src_idx = 10;
      pulse_start();
      send_beats(74, 100);
      ev_o = 1'b1;
      @(posedge clk); #1;
      ev_o = 1'b0;
      checks++; if (err !== 1'b1 || err_code !== 3'b100 || busy !== 1'b0) begin failures++;
         $display("FAIL ovf_err err=%b code=%b busy=%b want 1 100 0", err, err_code, busy); end
      send_beats(100, 100);
      checks++; if (nwr !== 0) begin failures++;
         $display("FAIL ovf_writes got=%0d want=0", nwr); end
      full_run(100);
      checks++; if (nwr !== 256 || log_addr[0] !== 8'd0 || log_addr[255] !== 8'd255) begin failures++;
         $display("FAIL ovf_rerun nwr=%0d first=%0d last=%0d want 256 0 255",
                  nwr, log_addr[0], log_addr[255]); end
      checks++; if (log_data[255] !== mk(437)) begin failures++;
         $display("FAIL ovf_rerun_data got=%h want=%h", log_data[255], mk(437)); end
      checks++; if (done !== 1'b1 || err !== 1'b0 || err_code !== 3'b000) begin failures++;
         $display("FAIL ovf_rerun_flags done=%b err=%b code=%b want 1 0 000", done, err, err_code); end
      ev_o = 1'b1; ev_u = 1'b1;  // ignored in DONE
      @(posedge clk); #1;
      ev_o = 1'b0; ev_u = 1'b0;
      wait_cyc(1);
      checks++; if (err !== 1'b0 || err_code !== 3'b000 || done !== 1'b1) begin failures++;
         $display("FAIL evt_in_done err=%b code=%b done=%b want 0 000 1", err, err_code, done); end
   endtask

   task automatic test_abort();
      nwr = 0; seq = 0; src_idx = 10;
      pulse_start();
      send_beats(54 + 128 + 101, 100);
      checks++; if (wr_en !== 1'b1 || wr_addr !== 8'd100) begin failures++;
         $display("FAIL abort_pre wr_en=%b addr=%0d want 1 100", wr_en, wr_addr); end
      abort = 1'b1; start = 1'b1;
      tvalid = 1'b1; tdata = mk(seq); tlast = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; tvalid = 1'b0;
      checks++; if ({busy, wr_en, done} !== 3'b000) begin failures++;
         $display("FAIL abort_next busy/wr_en/done=%b want 000", {busy, wr_en, done}); end
      seq++; src_idx = (src_idx + 1) % 64;
      send_beats(20, 100);
      checks++; if (nwr !== 101 || log_addr[100] !== 8'd100 || busy !== 1'b0) begin failures++;
         $display("FAIL abort_writes nwr=%0d last=%0d busy=%b want 101 100 0", nwr, log_addr[100], busy); end
      full_run(100);
      checks++; if (nwr !== 256 || log_addr[0] !== 8'd0 || log_data[0] !== mk(182)) begin failures++;
         $display("FAIL abort_rerun nwr=%0d addr0=%0d data0=%h want 256 0 %h",
                  nwr, log_addr[0], log_data[0], mk(182)); end
      checks++; if (done !== 1'b1) begin failures++;
         $display("FAIL abort_rerun_done got=%b want=1", done); end
   endtask

   task automatic test_reset_mid();
      nwr = 0; seq = 0; src_idx = 10;
      pulse_start();
      send_beats(54 + 128 + 50, 100);
      rst = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({tready, wr_en, busy, done, err} !== 5'b0 || err_code !== 3'b000) begin failures++;
         $display("FAIL rstmid_flags got=%b code=%b want 00000 000", {tready, wr_en, busy, done, err}, err_code); end
      checks++; if (wr_addr !== 8'd0 || frame_count !== 3'd0 || wr_data !== 32'd0) begin failures++;
         $display("FAIL rstmid_regs addr=%0d fc=%0d data=%h want 0 0 0", wr_addr, frame_count, wr_data); end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      send_beats(10, 100);
      checks++; if (nwr !== 50 || busy !== 1'b0) begin failures++;
         $display("FAIL rstmid_after nwr=%0d busy=%b want 50 0", nwr, busy); end
      full_run(100);
      checks++; if (nwr !== 256 || log_addr[255] !== 8'd255 || done !== 1'b1) begin failures++;
         $display("FAIL rstmid_rerun nwr=%0d last=%0d done=%b want 256 255 1", nwr, log_addr[255], done); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_gaps();
      test_tlast_err();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ospfb_capture_ctrl.md
OSPFB_CAPTURE_CTRL -- requirements
Module: ospfb_capture_ctrl

Interface
REQ-001 SHALL have parameter FFT_LEN, default 2048: samples per output frame; power of two, at least 8.
REQ-002 SHALL have parameter WIDTH, default 16: width of each real and imaginary component.
REQ-003 SHALL have parameter FRAMES, default 20: number of frames captured per run, at least 1.
REQ-004 SHALL have parameter SKIP_FRAMES, default 2: number of aligned frames discarded before capture, at least 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: arm request, sampled every cycle.
REQ-008 SHALL have port abort, input, 1 bit: cancel the current run.
REQ-009 SHALL have ports s_axis_tdata (input, 2*WIDTH), s_axis_tvalid (input, 1), s_axis_tready (output, 1) and s_axis_tlast (input, 1): the OSPFB/FFT output stream.
REQ-010 SHALL have ports event_tlast_unexpected, event_tlast_missing and event_fft_overflow, each input, 1 bit: FFT core event pulses.
REQ-011 SHALL have ports wr_en (output, 1), wr_addr (output, AW = $clog2(FRAMES*FFT_LEN)) and wr_data (output, 2*WIDTH): capture-RAM write port.
REQ-012 SHALL have ports busy, done and err, each output, 1 bit: status flags.
REQ-013 SHALL have port err_code, output, 3 bits: {fft_overflow, fft_tlast_event, local_tlast_mismatch}.
REQ-014 SHALL have port frame_count, output, $clog2(FRAMES+1) bits: number of frames fully captured.

Function
REQ-015 SHALL implement states IDLE, SYNC, SKIP, CAPTURE, DONE and ERROR.
REQ-016 SHALL drive s_axis_tready=1 in every state except during reset; a beat is accepted when tvalid and tready are both 1.
REQ-017 IDLE: start=1 and abort=0 SHALL go to SYNC and clear done, err, err_code and frame_count; all beats are discarded.
REQ-018 SYNC: SHALL discard beats until an accepted beat carries tlast=1, then go to SKIP, or to CAPTURE if SKIP_FRAMES=0.
REQ-019 SKIP: SHALL count accepted beats with a sample index 0..FFT_LEN-1; each index wrap counts one frame; after SKIP_FRAMES frames it SHALL go to CAPTURE.
REQ-020 CAPTURE: each accepted beat SHALL produce wr_en=1 exactly one cycle later, with wr_data equal to the registered tdata and wr_addr = frame*FFT_LEN + index.
REQ-021 CAPTURE: SHALL increment frame_count on the beat with index FFT_LEN-1; after frame FRAMES-1 it SHALL go to DONE.
REQ-022 SHALL hold the sample-index and frame counters when no beat is accepted; tvalid gaps SHALL NOT affect addressing.
REQ-023 SKIP/CAPTURE tlast check: tlast=1 at index != FFT_LEN-1, or tlast=0 at index FFT_LEN-1, SHALL go to ERROR with err_code[0]=1; the offending beat SHALL NOT be written.
REQ-024 SKIP/CAPTURE event inputs: event_fft_overflow SHALL set err_code[2]; either tlast event SHALL set err_code[1]; any event SHALL go to ERROR on the following cycle.
REQ-025 Event inputs SHALL be ignored in IDLE, SYNC, DONE and ERROR.
REQ-026 Multiple error causes arriving in the same cycle SHALL all be recorded in err_code.
REQ-027 DONE: done=1 SHALL be registered high in the same cycle as the final wr_en pulse and held; no further writes occur.
REQ-028 ERROR: err=1 SHALL be held and wr_en=0.
REQ-029 From DONE or ERROR, start SHALL re-arm exactly as from IDLE.
REQ-030 abort=1 in any state other than IDLE SHALL go to IDLE on the next cycle, suppress any pending write, and leave done=0; abort SHALL take priority over start and over all events.
REQ-031 start while busy SHALL be ignored.
REQ-032 busy SHALL equal 1 exactly in SYNC, SKIP and CAPTURE.
REQ-033 wr_addr SHALL never exceed FRAMES*FFT_LEN-1 and SHALL NOT wrap.

Reset
REQ-034 rst=1 SHALL force IDLE and drive s_axis_tready, wr_en, busy, done, err, err_code, wr_addr and frame_count to 0; wr_data resets to 0.
REQ-035 rst SHALL override start and abort in the same cycle; reset mid-capture discards the run with no further writes.

Verification (FFT_LEN=64, FRAMES=4, SKIP_FRAMES=2)
REQ-036 Start, then continuous stream with tlast every 64 beats, starting mid-frame at index 10 -> 54 beats discarded, 128 skipped, then 256 writes at addresses 0..255 in order; done=1 with the last write; frame_count=4.
REQ-037 Same stream with tvalid toggling randomly at 50% -> identical address/data sequence, no gaps in addresses.
REQ-038 tlast asserted at capture index 30 of frame 1 -> err=1, err_code=3'b001, last wr_addr=93, frame_count=1.
REQ-039 event_fft_overflow pulse during SKIP -> err=1, err_code=3'b100, no wr_en ever asserted; a following start -> full normal capture.
REQ-040 abort at capture address 100, with start asserted in the same cycle -> IDLE next cycle, no write at address 101, done=0; a later start -> capture restarts at address 0.
REQ-041 rst pulse during CAPTURE -> all outputs 0 on the next cycle; start after reset -> normal 256-write run.
